// File: rtl/nn_pkg.sv
// Shared types and helpers for the fully connected layer engine:
// FSM state encoding, default accumulator width and output post-processing.
package nn_pkg;

    // Layer engine sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BIAS  = 2'd1,
        MAC   = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int FRAC_W_DEF = 4;

    // Accumulator wide enough for 2**addr_w full-scale products plus bias
    function automatic int acc_width(input int data_w, input int addr_w);
        return 2 * data_w + addr_w;
    endfunction

    localparam int ACC_W_DEF = acc_width(DATA_W_DEF, ADDR_W_DEF);

    // Rescale Q-format accumulator, optional ReLU, then clamp to a signed data_w word.
    // Works on a 64-bit container so it serves any parameterisation; callers truncate.
    function automatic logic signed [63:0] post_process(
        input logic signed [63:0] acc,
        input int                 frac_w,
        input int                 data_w,
        input logic               relu
    );
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        r     = acc >>> frac_w;
        max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (data_w - 1));
        if (relu && (r < 64'sd0)) begin
            r = 64'sd0;
        end
        if (r > max_v) begin
            r = max_v;
        end else if (r < min_v) begin
            r = min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_ram.sv
// Neuron RAM: one write port, two combinational engine read ports
// (input vector and weight record) and one registered host read port.
module neuron_ram
    import nn_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_adr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_adr_a,
    output logic [DATA_W-1:0] o_rd_data_a,
    input  logic [ADDR_W-1:0] i_rd_adr_b,
    output logic [DATA_W-1:0] o_rd_data_b,
    input  logic [ADDR_W-1:0] i_host_rd_adr,
    output logic [DATA_W-1:0] o_host_rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_host_rd_data;

    // Storage array; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_adr] <= i_wr_data;
        end
    end

    assign o_rd_data_a = r_mem[i_rd_adr_a];
    assign o_rd_data_b = r_mem[i_rd_adr_b];

    // Host read port: one cycle latency, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_host_rd_data <= '0;
        end else begin
            r_host_rd_data <= r_mem[i_host_rd_adr];
        end
    end

    assign o_host_rd_data = r_host_rd_data;

endmodule

// File: rtl/neural_layer_engine.sv
// Fully connected layer engine: for each output neuron j, loads its bias,
// accumulates in_count signed products, rescales / ReLUs / saturates and
// writes one word back into the shared neuron RAM.
// Handshake: start is a one-cycle request, accepted only while busy=0;
// busy covers the whole layer and finished is a sticky done flag that is
// cleared by the next accepted start.
module neural_layer_engine
    import nn_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int FRAC_W = 4,
    parameter int ACC_W  = acc_width(DATA_W, ADDR_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] neuron_ram_write_adr_ext,
    input  logic [DATA_W-1:0] neuron_ram_write_data_ext,
    input  logic              neuron_ram_wr_en_ext,
    input  logic [ADDR_W-1:0] neuron_ram_read_adr_ext,
    output logic [DATA_W-1:0] neuron_ram_read_data_ext,
    input  logic              start,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [ADDR_W-1:0] in_count,
    input  logic [ADDR_W-1:0] out_count,
    input  logic              relu_en,
    output logic              busy,
    output logic              finished,
    output logic [ADDR_W-1:0] result_base_address,
    output logic [ADDR_W-1:0] result_word_count,
    output logic [1:0]        o_dbg_state
);

    state_t r_state;
    state_t w_next_state;

    logic [ADDR_W-1:0]       r_in_base;
    logic [ADDR_W-1:0]       r_out_base;
    logic [ADDR_W-1:0]       r_in_count;
    logic [ADDR_W-1:0]       r_out_count;
    logic [ADDR_W-1:0]       r_i;
    logic [ADDR_W-1:0]       r_j;
    logic [ADDR_W-1:0]       r_rec_ptr;
    logic                    r_relu;
    logic                    r_finished;
    logic signed [ACC_W-1:0] r_acc;

    logic                      w_start_acc;
    logic                      w_last_i;
    logic                      w_last_j;
    logic                      w_busy;
    logic                      w_eng_we;
    logic [ADDR_W-1:0]         w_in_rd_adr;
    logic [ADDR_W-1:0]         w_w_rd_adr;
    logic [ADDR_W-1:0]         w_eng_wr_adr;
    logic [DATA_W-1:0]         w_x_raw;
    logic [DATA_W-1:0]         w_w_raw;
    logic signed [DATA_W-1:0]  w_x;
    logic signed [DATA_W-1:0]  w_w;
    logic signed [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]         w_result;
    logic                      w_ram_we;
    logic [ADDR_W-1:0]         w_ram_wr_adr;
    logic [DATA_W-1:0]         w_ram_wr_data;

    assign w_start_acc = start && (r_state == IDLE);
    assign w_last_i    = (r_i == (r_in_count - ADDR_W'(1)));
    assign w_last_j    = (r_j == (r_out_count - ADDR_W'(1)));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: one BIAS, in_count MACs and one WRITE per neuron
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_acc && (out_count != '0)) w_next_state = BIAS;
            BIAS:    w_next_state = (r_in_count == '0) ? WRITE : MAC;
            MAC:     if (w_last_i) w_next_state = WRITE;
            WRITE:   w_next_state = w_last_j ? IDLE : BIAS;
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode: status, engine read/write addresses and write strobe
    always_comb begin
        w_busy       = (r_state != IDLE);
        w_eng_we     = (r_state == WRITE);
        w_in_rd_adr  = r_in_base + r_i;
        w_w_rd_adr   = (r_state == BIAS) ? r_rec_ptr : (r_rec_ptr + r_i + ADDR_W'(1));
        w_eng_wr_adr = r_out_base + r_j;
    end

    // Host writes are dropped while the layer runs, so the port never collides
    assign w_ram_we      = w_eng_we || (neuron_ram_wr_en_ext && !w_busy);
    assign w_ram_wr_adr  = w_eng_we ? w_eng_wr_adr : neuron_ram_write_adr_ext;
    assign w_ram_wr_data = w_eng_we ? w_result : neuron_ram_write_data_ext;

    neuron_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk            (clk),
        .rst_n          (reset),
        .i_we           (w_ram_we),
        .i_wr_adr       (w_ram_wr_adr),
        .i_wr_data      (w_ram_wr_data),
        .i_rd_adr_a     (w_in_rd_adr),
        .o_rd_data_a    (w_x_raw),
        .i_rd_adr_b     (w_w_rd_adr),
        .o_rd_data_b    (w_w_raw),
        .i_host_rd_adr  (neuron_ram_read_adr_ext),
        .o_host_rd_data (neuron_ram_read_data_ext)
    );

    assign w_x    = signed'(w_x_raw);
    assign w_w    = signed'(w_w_raw);
    assign w_prod = w_x * w_w;

    // During BIAS the weight port points at the bias word of the record
    assign w_result = DATA_W'(post_process(64'(r_acc), FRAC_W, DATA_W, r_relu));

    // Datapath: layer parameter latch, counters, record pointer and accumulator
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_base   <= '0;
            r_out_base  <= '0;
            r_in_count  <= '0;
            r_out_count <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_rec_ptr   <= '0;
            r_relu      <= 1'b0;
            r_finished  <= 1'b0;
            r_acc       <= '0;
        end else if (w_start_acc) begin
            r_in_base   <= in_base;
            r_out_base  <= out_base;
            r_in_count  <= in_count;
            r_out_count <= out_count;
            r_relu      <= relu_en;
            r_rec_ptr   <= w_base;
            r_i         <= '0;
            r_j         <= '0;
            // An empty layer completes immediately
            r_finished  <= (out_count == '0);
        end else begin
            case (r_state)
                BIAS: begin
                    r_acc <= ACC_W'(w_w) <<< FRAC_W;
                    r_i   <= '0;
                end
                MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    r_i   <= r_i + ADDR_W'(1);
                end
                WRITE: begin
                    if (w_last_j) begin
                        r_finished <= 1'b1;
                    end else begin
                        r_j       <= r_j + ADDR_W'(1);
                        r_rec_ptr <= r_rec_ptr + r_in_count + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy                = w_busy;
    assign finished            = r_finished;
    assign result_base_address = r_out_base;
    assign result_word_count   = r_out_count;
    assign o_dbg_state         = r_state;

endmodule

// File: doc/neural_layer_engine.md
# neural_layer_engine

Parametrised successor to the fixed 8-bit neural accelerator. Evaluates one fully connected layer from a shared neuron RAM: signed fixed-point multiply-accumulate, bias, optional ReLU, saturation, then write-back of one word per output neuron. Host loads inputs and weights through the external RAM ports, pulses `start`, waits for `finished`, then reads results through the same external read port.

## Interface
Parameters:
- `DATA_W`, 8: signed word width (RAM, inputs, weights, outputs).
- `ADDR_W`, 8: RAM address width; depth is 2**ADDR_W.
- `FRAC_W`, 4: fractional bits of the Q format.
- `ACC_W`, 2*DATA_W+ADDR_W: accumulator width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `neuron_ram_write_adr_ext` in ADDR_W: host write address.
- `neuron_ram_write_data_ext` in DATA_W: host write data.
- `neuron_ram_wr_en_ext` in 1: host write enable.
- `neuron_ram_read_adr_ext` in ADDR_W: host read address.
- `neuron_ram_read_data_ext` out DATA_W: registered host read data.
- `start` in 1: one-cycle layer start pulse.
- `in_base`, `w_base`, `out_base` in ADDR_W: input, weight and output region bases.
- `in_count`, `out_count` in ADDR_W: inputs per neuron, number of output neurons.
- `relu_en` in 1: clamp negative results to 0.
- `busy` out 1: layer in progress.
- `finished` out 1: sticky completion flag.
- `result_base_address` out ADDR_W: `out_base` latched at start.
- `result_word_count` out ADDR_W: `out_count` latched at start.

## Operation
- Memory layout: neuron j record at `w_base + j*(in_count+1)`: word 0 is bias, words 1..in_count are weights. Input i at `in_base+i`. Output j written to `out_base+j`. All address arithmetic is modulo 2**ADDR_W.
- `start` accepted only when not busy. Latches bases, counts and `relu_en`, clears `finished`, and sets `busy`. Ignored while busy.
- FSM: IDLE -> BIAS (on start, out_count≠0) -> MAC ×in_count -> WRITE -> BIAS (next j) or IDLE (last j). BIAS: acc = sign_ext(bias) << FRAC_W. MAC: acc += x_i*w_i (signed). WRITE: r = acc >>> FRAC_W; if relu_en and r<0, r=0; saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; store.
- `in_count`=0: BIAS goes directly to WRITE (output = saturated bias). `out_count`=0: no writes; `finished` is set one cycle after start.
- Host writes are accepted only when `busy`=0. While busy they are dropped. Host reads are always served and may observe partial results.
- Reset: FSM to IDLE; `busy`, `finished`, `result_*` and `neuron_ram_read_data_ext` go to 0. RAM contents are not cleared. Reset mid-layer abandons the layer; words already written remain.

## Timing
- Internal engine reads: combinational, two ports (input, weight). Host read: 1-cycle latency.
- Start sampled at edge 0. Each neuron occupies in_count+2 cycles. `busy` is high for out_count*(in_count+2) cycles. `finished` rises at the same edge `busy` falls and stays high until the next accepted start.
- The output word write takes effect on the edge ending WRITE.
- Host write and engine write are never simultaneous, because host writes are gated by `busy`.

## Structure
- Package `nn_pkg`: FSM state enum (IDLE, BIAS, MAC, WRITE), the default ACC_W expression, and the saturate/ReLU function.
- Sub-module `neuron_ram`: 2**ADDR_W × DATA_W, one write port (muxed host/engine), two combinational engine read ports, one registered host read port.
- Top level: FSM, counters i/j, record pointer, accumulator, post-processing.

## Test plan
- Basic MAC: x=[16,32], bias0=1, w0=[16,16], in_count=2, out_count=1 -> out=49 (0x31). `busy` lasts 4 cycles, then `finished`=1.
- ReLU: neuron1 bias 0, w=[-16,-16], same x. relu_en=0 -> 0xD0 (-48); relu_en=1 -> 0x00. With out_count=2, `busy` lasts 8 cycles.
- Saturation: x=[127,127], w=[127,127], bias 0 -> 0x7F. Same case with w=[-128,-128] and relu_en=0 -> 0x80.
- Edge counts: in_count=0, bias=-5 -> out=0xFB. out_count=0 -> no RAM change and `finished` one cycle after start.
- Protocol: start while busy is ignored; a host write while busy is dropped (read back unchanged); `result_base_address`/`result_word_count` match the latched values; addresses wrap correctly with out_base=0xFF, out_count=2 (writes to 0xFF and 0x00).
- Reset mid-layer: drop `reset` during MAC -> `busy`=0, `finished`=0, read data 0. A fresh start after release completes correctly.
